exe_issue_arbiter: RTL and testbench

//  Round-robin scheduler sharing the single EXE/ALU datapath among NUM_RS reservation stations.

---
 rtl/exe_sched_pkg.sv | 25 ++
 rtl/rr_priority_pick.sv | 28 ++
 rtl/exe_issue_arbiter.sv | 144 ++++++++++++++
 tb/tb_exe_issue_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/exe_sched_pkg.sv
// Shared types and constants for the EXE issue arbiter: state encoding,
// default sizing and a one-hot to index helper.
package exe_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_MULDIV = 2'd2
  } sched_state_e;

  localparam int DEF_NUM_RS     = 4;
  localparam int DEF_UID_W      = 32;
  localparam int DEF_MULDIV_LAT = 4;

  // Supports up to 8 requesters; callers zero-extend narrower vectors.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate the eligible set so ptr sits at bit 0,
// take the lowest set bit, then rotate the one-hot result back.
module rr_priority_pick
  import exe_sched_pkg::*;
#(
  parameter int N = DEF_NUM_RS,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;

  always_comb begin
    rot     = N'({elig, elig} >> ptr);
    rot_oh  = rot & (~rot + N'(1));
    // Upper half of the doubled, left-shifted vector is the un-rotated one-hot.
    win_oh  = N'(({rot_oh, rot_oh} << ptr) >> N);
    win_idx = IDX_W'(onehot_to_idx(8'(win_oh)));
    any     = |elig;
  end

endmodule

// File: rtl/exe_issue_arbiter.sv
// Round-robin issue arbiter sharing the EXE datapath among NUM_RS reservation stations.
// Define MULDIV_LOCK_EN to lock EXE for MULDIV_LAT cycles after a MULT/DIV grant.
module exe_issue_arbiter
  import exe_sched_pkg::*;
#(
  parameter int NUM_RS     = DEF_NUM_RS,
  parameter int UID_W      = DEF_UID_W,
  parameter int MULDIV_LAT = DEF_MULDIV_LAT,
  localparam int SEL_W     = $clog2(NUM_RS)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_RS-1:0]       req_valid,
  input  logic [NUM_RS-1:0]       req_muldiv,
  input  logic [NUM_RS*UID_W-1:0] req_uid,
  input  logic                    stall_fMEM,
  output logic [NUM_RS-1:0]       grant,
  output logic                    issue_valid,
  output logic [SEL_W-1:0]        issue_sel,
  output logic [UID_W-1:0]        issue_uid,
  output logic                    exe_busy,
  output logic [1:0]              dbg_state
);

  // Handshake: req_valid[i] stays high until grant[i] is seen; the granted RS
  // drops its request the following cycle, so grant_q masks it for one edge.

  sched_state_e      state_q, state_d;
  logic [NUM_RS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  rr_q, rr_d;
  logic [UID_W-1:0]  uid_q, uid_d;
  logic [NUM_RS-1:0] elig, win_oh;
  logic [SEL_W-1:0]  win_idx;
  logic              win_any;
  logic              issue;

`ifdef MULDIV_LOCK_EN
  localparam int CNT_W = $clog2(MULDIV_LAT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             md_q, md_d;
`else
  logic unused_muldiv;
  assign unused_muldiv = ^{req_muldiv, 32'(MULDIV_LAT)};
`endif

  assign elig = req_valid & ~grant_q;

  rr_priority_pick #(.N(NUM_RS)) u_pick (
    .elig    (elig),
    .ptr     (rr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    sel_d   = sel_q;
    uid_d   = uid_q;
    rr_d    = rr_q;
    issue   = 1'b0;
`ifdef MULDIV_LOCK_EN
    cnt_d  = cnt_q;
    busy_d = 1'b0;
    md_d   = 1'b0;
    unique case (state_q)
      ST_MULDIV: begin
        // The ALU keeps counting through MEM stalls; the last busy cycle may hand off.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) issue = ~stall_fMEM & win_any;
        else                    busy_d = 1'b1;
      end
      ST_GRANT: begin
        if (md_q) begin
          cnt_d  = CNT_W'(MULDIV_LAT - 1);
          busy_d = 1'b1;
        end else begin
          issue = ~stall_fMEM & win_any;
        end
      end
      default: issue = ~stall_fMEM & win_any;
    endcase
`else
    issue = ~stall_fMEM & win_any;
`endif
    if (issue) begin
      grant_d = win_oh;
      sel_d   = win_idx;
      uid_d   = req_uid[int'(win_idx)*UID_W +: UID_W];
      rr_d    = (win_idx == SEL_W'(NUM_RS - 1)) ? '0 : win_idx + SEL_W'(1);
      state_d = ST_GRANT;
`ifdef MULDIV_LOCK_EN
      md_d    = req_muldiv[win_idx];
    end else if (busy_d) begin
      state_d = ST_MULDIV;
`endif
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      uid_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      uid_q   <= uid_d;
      rr_q    <= rr_d;
    end
  end

`ifdef MULDIV_LOCK_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      md_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      md_q   <= md_d;
    end
  end
  assign exe_busy = busy_q;
`else
  assign exe_busy = 1'b0;
`endif

  assign grant       = grant_q;
  assign issue_valid = |grant_q;
  assign issue_sel   = sel_q;
  assign issue_uid   = uid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_exe_issue_arbiter.sv
// Directed table-driven bench for exe_issue_arbiter (4 RS, 32-bit UID, MULDIV_LAT=4);
// expectations switch on MULDIV_LOCK_EN to match the build being simulated.
module tb_exe_issue_arbiter;

  logic         CLK;
  logic         RESET;
  logic [3:0]   req_valid;
  logic [3:0]   req_muldiv;
  logic [127:0] req_uid;
  logic         stall_fMEM;
  logic [3:0]   grant;
  logic         issue_valid;
  logic [1:0]   issue_sel;
  logic [31:0]  issue_uid;
  logic         exe_busy;
  logic [1:0]   dbg_state;

  localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_MULDIV = 2'd2;

  typedef struct {
    logic [3:0] req;
    logic [3:0] md;
    logic       stall;
    logic [3:0] g;
    logic [1:0] sel;
    logic       busy;
    logic [1:0] st;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] uid_tab[4];
  int          n_vec  = 0;
  int          n_miss = 0;

  exe_issue_arbiter #(.NUM_RS(4), .UID_W(32), .MULDIV_LAT(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_muldiv  (req_muldiv),
    .req_uid     (req_uid),
    .stall_fMEM  (stall_fMEM),
    .grant       (grant),
    .issue_valid (issue_valid),
    .issue_sel   (issue_sel),
    .issue_uid   (issue_uid),
    .exe_busy    (exe_busy),
    .dbg_state   (dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] md, input logic stall,
                     input logic [3:0] g, input logic [1:0] sel, input logic busy,
                     input logic [1:0] st);
    vec_t v;
    v.req = req; v.md = md; v.stall = stall;
    v.g = g; v.sel = sel; v.busy = busy; v.st = st;
    vt.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) uid_tab[i] = 32'hC0DE_0100 + 32'(i * 17);
    req_uid = {uid_tab[3], uid_tab[2], uid_tab[1], uid_tab[0]};

    // Fairness with every RS requesting; the last winner drops its request for one cycle.
    add(4'hF, 4'h0, 1'b0, 4'b0001, 2'd0, 1'b0, S_GRANT);
    add(4'hE, 4'h0, 1'b0, 4'b0010, 2'd1, 1'b0, S_GRANT);
    add(4'hD, 4'h0, 1'b0, 4'b0100, 2'd2, 1'b0, S_GRANT);
    add(4'hB, 4'h0, 1'b0, 4'b1000, 2'd3, 1'b0, S_GRANT);
    add(4'h7, 4'h0, 1'b0, 4'b0001, 2'd0, 1'b0, S_GRANT);
    add(4'hE, 4'h0, 1'b0, 4'b0010, 2'd1, 1'b0, S_GRANT);
    add(4'hD, 4'h0, 1'b0, 4'b0100, 2'd2, 1'b0, S_GRANT);
    add(4'hB, 4'h0, 1'b0, 4'b1000, 2'd3, 1'b0, S_GRANT);
    // MEM stall for three cycles, then RS2 issues; sel/uid hold meanwhile.
    add(4'h4, 4'h0, 1'b1, 4'b0000, 2'd3, 1'b0, S_IDLE);
    add(4'h4, 4'h0, 1'b1, 4'b0000, 2'd3, 1'b0, S_IDLE);
    add(4'h4, 4'h0, 1'b1, 4'b0000, 2'd3, 1'b0, S_IDLE);
    add(4'h4, 4'h0, 1'b0, 4'b0100, 2'd2, 1'b0, S_GRANT);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 2'd2, 1'b0, S_IDLE);
    // Pointer wrap: ptr=3 with only RS0/RS1 requesting.
    add(4'h3, 4'h0, 1'b0, 4'b0001, 2'd0, 1'b0, S_GRANT);
    add(4'h2, 4'h0, 1'b0, 4'b0010, 2'd1, 1'b0, S_GRANT);
    add(4'h1, 4'h0, 1'b0, 4'b0001, 2'd0, 1'b0, S_GRANT);
    add(4'h8, 4'h0, 1'b0, 4'b1000, 2'd3, 1'b0, S_GRANT);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 2'd3, 1'b0, S_IDLE);
    // RS0 MULT/DIV with RS1 waiting.
    add(4'h3, 4'h1, 1'b0, 4'b0001, 2'd0, 1'b0, S_GRANT);
`ifdef MULDIV_LOCK_EN
    add(4'h2, 4'h0, 1'b0, 4'b0000, 2'd0, 1'b1, S_MULDIV);
    add(4'h2, 4'h0, 1'b0, 4'b0000, 2'd0, 1'b1, S_MULDIV);
    add(4'h2, 4'h0, 1'b0, 4'b0000, 2'd0, 1'b1, S_MULDIV);
    add(4'h2, 4'h0, 1'b0, 4'b0010, 2'd1, 1'b0, S_GRANT);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 2'd1, 1'b0, S_IDLE);
    // Stall held across the final busy cycle: counter ends, no hand-off.
    add(4'h4, 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0, S_GRANT);
    add(4'h1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b1, S_MULDIV);
    add(4'h1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b1, S_MULDIV);
    add(4'h1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b1, S_MULDIV);
    add(4'h1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b0, S_IDLE);
`else
    add(4'h2, 4'h0, 1'b0, 4'b0010, 2'd1, 1'b0, S_GRANT);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 2'd1, 1'b0, S_IDLE);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 2'd1, 1'b0, S_IDLE);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 2'd1, 1'b0, S_IDLE);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 2'd1, 1'b0, S_IDLE);
    add(4'h4, 4'h4, 1'b0, 4'b0100, 2'd2, 1'b0, S_GRANT);
    add(4'h1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b0, S_IDLE);
    add(4'h1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b0, S_IDLE);
    add(4'h1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b0, S_IDLE);
    add(4'h1, 4'h0, 1'b1, 4'b0000, 2'd2, 1'b0, S_IDLE);
`endif
    add(4'h1, 4'h0, 1'b0, 4'b0001, 2'd0, 1'b0, S_GRANT);
    add(4'h0, 4'h0, 1'b0, 4'b0000, 2'd0, 1'b0, S_IDLE);

    // Reset held with all RS requesting.
    RESET = 1'b1; req_valid = 4'hF; req_muldiv = 4'h0; stall_fMEM = 1'b0;
    repeat (2) tick();
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst issue_valid", 32'(issue_valid), 32'h0);
    chk("rst issue_sel", 32'(issue_sel), 32'h0);
    chk("rst issue_uid", issue_uid, 32'h0);
    chk("rst exe_busy", 32'(exe_busy), 32'h0);
    chk("rst state", 32'(dbg_state), 32'(S_IDLE));
    RESET = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      req_valid  = vt[i].req;
      req_muldiv = vt[i].md;
      stall_fMEM = vt[i].stall;
      tick();
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vt[i].g));
      chk($sformatf("v%0d issue_valid", i), 32'(issue_valid), 32'(|vt[i].g));
      chk($sformatf("v%0d issue_sel", i), 32'(issue_sel), 32'(vt[i].sel));
      chk($sformatf("v%0d issue_uid", i), issue_uid, uid_tab[vt[i].sel]);
      chk($sformatf("v%0d exe_busy", i), 32'(exe_busy), 32'(vt[i].busy));
      chk($sformatf("v%0d state", i), 32'(dbg_state), 32'(vt[i].st));
    end

    // Asynchronous reset landing while the counter sits at 2 (lock build).
    req_valid = 4'h2; req_muldiv = 4'h2; stall_fMEM = 1'b0;
    tick();
    chk("ar grant RS1", 32'(grant), 32'h2);
    req_valid = 4'h0; req_muldiv = 4'h0;
    tick();
    tick();
`ifdef MULDIV_LOCK_EN
    chk("ar pre busy", 32'(exe_busy), 32'h1);
    chk("ar pre state", 32'(dbg_state), 32'(S_MULDIV));
`else
    chk("ar pre busy", 32'(exe_busy), 32'h0);
    chk("ar pre state", 32'(dbg_state), 32'(S_IDLE));
`endif
    #2;
    RESET = 1'b1;
    req_valid = 4'h8;
    #1;
    chk("ar grant", 32'(grant), 32'h0);
    chk("ar issue_valid", 32'(issue_valid), 32'h0);
    chk("ar issue_sel", 32'(issue_sel), 32'h0);
    chk("ar issue_uid", issue_uid, 32'h0);
    chk("ar exe_busy", 32'(exe_busy), 32'h0);
    chk("ar state", 32'(dbg_state), 32'(S_IDLE));
    tick();
    chk("ar held grant", 32'(grant), 32'h0);
    RESET = 1'b0;
    tick();
    chk("ar post grant", 32'(grant), 32'h8);
    chk("ar post issue_valid", 32'(issue_valid), 32'h1);
    chk("ar post issue_sel", 32'(issue_sel), 32'h3);
    chk("ar post issue_uid", issue_uid, uid_tab[3]);
    chk("ar post state", 32'(dbg_state), 32'(S_GRANT));
    req_valid = 4'h0;
    tick();
    chk("ar idle grant", 32'(grant), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
